// File: rtl/fan_ctrl_pkg.sv
// Shared types and default constants for the multi-channel fan PWM controller.
// The optional kick-start feature is selected with the FAN_PWM_KICK_EN macro.
package fan_ctrl_pkg;

  typedef enum logic {
    RAMP_OFF = 1'b0,
    RAMP_ON  = 1'b1
  } ramp_mode_e;

  localparam int DefNumCh   = 2;
  localparam int DefDutyW   = 4;
  localparam int DefClkDiv  = 50;
  localparam int DefRampDiv = 4;
  localparam int DefKickPer = 8;

  // A single channel still needs a one-bit select so the port never collapses.
  function automatic int chWidth(input int numCh);
    return (numCh > 1) ? $clog2(numCh) : 1;
  endfunction

endpackage

// File: rtl/fan_pwm_multi_ctrl_if.sv
// Setpoint-write interface between a config master (e.g. a regfile) and the fan controller.
interface fan_pwm_multi_ctrl_if #(
  parameter int CH_W   = 1,
  parameter int DUTY_W = 4
);

  logic              cfg_valid_i;
  logic              cfg_ready_o;
  logic [CH_W-1:0]   cfg_ch_i;
  logic [DUTY_W-1:0] cfg_duty_i;
  logic              cfg_ramp_i;
  logic              cfg_err_o;

  modport master (
    output cfg_valid_i,
    output cfg_ch_i,
    output cfg_duty_i,
    output cfg_ramp_i,
    input  cfg_ready_o,
    input  cfg_err_o
  );

  modport slave (
    input  cfg_valid_i,
    input  cfg_ch_i,
    input  cfg_duty_i,
    input  cfg_ramp_i,
    output cfg_ready_o,
    output cfg_err_o
  );

endinterface

// File: rtl/fan_pwm_channel.sv
// One fan channel: target/applied duty, slew-limited ramp, registered compare output.
// Kick-start (forced full-on after leaving 0) exists only when FAN_PWM_KICK_EN is defined.
module fan_pwm_channel
  import fan_ctrl_pkg::*;
#(
  parameter int DUTY_W   = DefDutyW,
  parameter int RAMP_DIV = DefRampDiv,
  parameter int KICK_PER = DefKickPer
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_wrEn,
  input  logic [DUTY_W-1:0] i_wrDuty,
  input  ramp_mode_e        i_wrRamp,
  input  logic              i_periodEnd,
  input  logic [DUTY_W-1:0] i_phase,
  output logic              o_pwm,
  output logic [DUTY_W-1:0] o_duty,
  output logic              o_busy
);

  localparam int STEP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [STEP_W-1:0] StepLast = STEP_W'(RAMP_DIV - 1);

  logic [DUTY_W-1:0] r_target;
  ramp_mode_e        r_rampMode;
  logic [DUTY_W-1:0] r_applied;
  logic [STEP_W-1:0] r_step;
  logic              r_pwm;
  logic [DUTY_W-1:0] w_appliedNext;
  logic [STEP_W-1:0] w_stepNext;
  logic              w_kickActive;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_target   <= '0;
      r_rampMode <= RAMP_OFF;
    end else if (i_wrEn) begin
      r_target   <= i_wrDuty;
      r_rampMode <= i_wrRamp;
    end
  end

  // Value the applied duty takes at the coming period boundary; a ramp only steps on counter wrap.
  always_comb begin
    w_appliedNext = r_applied;
    w_stepNext    = '0;
    if (r_rampMode == RAMP_OFF) begin
      w_appliedNext = r_target;
    end else if (r_applied != r_target) begin
      if (r_step == StepLast) begin
        w_appliedNext = (r_applied < r_target) ? r_applied + 1'b1 : r_applied - 1'b1;
      end else begin
        w_stepNext = r_step + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_applied <= '0;
      r_step    <= '0;
    end else if (i_periodEnd) begin
      r_applied <= w_appliedNext;
      r_step    <= w_stepNext;
    end
  end

`ifdef FAN_PWM_KICK_EN
  localparam int KICK_W = $clog2(KICK_PER + 1);

  logic [KICK_W-1:0] r_kick;

  // Counts remaining full-on periods; a zero target seen at a boundary cancels the kick.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_kick <= '0;
    end else if (i_periodEnd) begin
      if ((r_applied == '0) && (w_appliedNext != '0)) begin
        r_kick <= KICK_W'(KICK_PER);
      end else if (r_kick != '0) begin
        r_kick <= (r_target == '0) ? '0 : r_kick - 1'b1;
      end
    end
  end

  assign w_kickActive = (r_kick != '0);
`else
  logic [31:0] w_unusedKickPer;

  assign w_unusedKickPer = KICK_PER;
  assign w_kickActive    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_kickActive || (i_phase < r_applied);
    end
  end

  assign o_pwm  = r_pwm;
  assign o_duty = r_applied;
  assign o_busy = (r_applied != r_target) || w_kickActive;

endmodule

// File: rtl/fan_pwm_multi_ctrl.sv
// Multi-channel fan PWM controller: shared prescaler/phase counter, config decode, NUM_CH channels.
// Define FAN_PWM_KICK_EN to enable per-channel kick-start.
module fan_pwm_multi_ctrl
  import fan_ctrl_pkg::*;
#(
  parameter int NUM_CH   = DefNumCh,
  parameter int DUTY_W   = DefDutyW,
  parameter int CLK_DIV  = DefClkDiv,
  parameter int RAMP_DIV = DefRampDiv,
  parameter int KICK_PER = DefKickPer
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  fan_pwm_multi_ctrl_if.slave      cfg,
  output logic [NUM_CH-1:0]        fan_pwm_o,
  output logic [NUM_CH*DUTY_W-1:0] duty_o,
  output logic [NUM_CH-1:0]        busy_o
);

  localparam int CH_W    = chWidth(NUM_CH);
  localparam int PRESC_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int PMAX    = (2 ** DUTY_W) - 1;
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(CLK_DIV - 1);
  localparam logic [DUTY_W-1:0]  PhaseLast = DUTY_W'(PMAX - 1);

  logic [PRESC_W-1:0] r_presc;
  logic [DUTY_W-1:0]  r_phase;
  logic               r_ready;
  logic               r_err;
  logic               w_tick;
  logic               w_periodEnd;
  logic               w_accept;
  logic               w_chOk;

  assign w_tick      = (r_presc == PrescLast);
  assign w_periodEnd = w_tick && (r_phase == PhaseLast);

  // The phase runs 0..PMAX-1 so a duty of PMAX keeps the output high across the wrap.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_presc <= '0;
      r_phase <= '0;
    end else if (w_tick) begin
      r_presc <= '0;
      r_phase <= (r_phase == PhaseLast) ? '0 : r_phase + 1'b1;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  always_comb begin
    w_chOk = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cfg.cfg_ch_i == CH_W'(c)) begin
        w_chOk = 1'b1;
      end
    end
  end

  assign w_accept = cfg.cfg_valid_i && r_ready;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ready <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ready <= 1'b1;
      r_err   <= w_accept && !w_chOk;
    end
  end

  assign cfg.cfg_ready_o = r_ready;
  assign cfg.cfg_err_o   = r_err;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fan_pwm_channel #(
      .DUTY_W   (DUTY_W),
      .RAMP_DIV (RAMP_DIV),
      .KICK_PER (KICK_PER)
    ) u_channel (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .i_wrEn      (w_accept && (cfg.cfg_ch_i == CH_W'(g))),
      .i_wrDuty    (cfg.cfg_duty_i),
      .i_wrRamp    (ramp_mode_e'(cfg.cfg_ramp_i)),
      .i_periodEnd (w_periodEnd),
      .i_phase     (r_phase),
      .o_pwm       (fan_pwm_o[g]),
      .o_duty      (duty_o[g*DUTY_W +: DUTY_W]),
      .o_busy      (busy_o[g])
    );
  end

endmodule

// File: tb/tb_fan_pwm_multi_ctrl.sv
// Directed bench for fan_pwm_multi_ctrl (NUM_CH=3, DUTY_W=4, CLK_DIV=4, RAMP_DIV=2): period = 60 clocks.
// cycleN counts clocks since the last reset edge, so period boundaries fall on multiples of 60.
module tb_fan_pwm_multi_ctrl;

  localparam int NUM_CH = 3;
  localparam int DUTY_W = 4;

  logic                     clk;
  logic                     rst;
  logic [NUM_CH-1:0]        fanPwm;
  logic [NUM_CH*DUTY_W-1:0] duty;
  logic [NUM_CH-1:0]        busy;
  int                       cycleN;
  int                       checkCount;
  int                       passCount;
  int                       failCount;
  int                       highCnt;

  fan_pwm_multi_ctrl_if #(.CH_W(2), .DUTY_W(DUTY_W)) cfgIf ();

  fan_pwm_multi_ctrl #(
    .NUM_CH   (NUM_CH),
    .DUTY_W   (DUTY_W),
    .CLK_DIV  (4),
    .RAMP_DIV (2),
    .KICK_PER (2)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .cfg       (cfgIf.slave),
    .fan_pwm_o (fanPwm),
    .duty_o    (duty),
    .busy_o    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) cycleN <= 0;
    else     cycleN <= cycleN + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h at cycle %0d", tag, observed, expected, cycleN);
    end
  endtask

  task automatic stepTo(input int target);
    while (cycleN < target) @(negedge clk);
  endtask

  // Presents one write for a single cycle; returns one negedge later.
  task automatic applyStimulus(input logic [1:0] ch, input logic [3:0] dutyVal, input logic ramp);
    cfgIf.cfg_valid_i = 1'b1;
    cfgIf.cfg_ch_i    = ch;
    cfgIf.cfg_duty_i  = dutyVal;
    cfgIf.cfg_ramp_i  = ramp;
    @(negedge clk);
    cfgIf.cfg_valid_i = 1'b0;
  endtask

  task automatic countHigh(input int fromN, input int toN, input int ch, output int cnt);
    cnt = 0;
    stepTo(fromN);
    while (cycleN <= toN) begin
      if (fanPwm[ch]) cnt++;
      @(negedge clk);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_ready"}, 32'(cfgIf.cfg_ready_o), 32'h0);
    checkOutput({tag, "_pwm"},   32'(fanPwm), 32'h0);
    checkOutput({tag, "_duty"},  32'(duty),   32'h0);
    checkOutput({tag, "_busy"},  32'(busy),   32'h0);
    checkOutput({tag, "_err"},   32'(cfgIf.cfg_err_o), 32'h0);
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst = 1'b1;
    cfgIf.cfg_valid_i = 1'b0;
    cfgIf.cfg_ch_i    = '0;
    cfgIf.cfg_duty_i  = '0;
    cfgIf.cfg_ramp_i  = 1'b0;
    repeat (3) @(negedge clk);
    checkResetState("por");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst", 32'(cfgIf.cfg_ready_o), 32'h1);

    // ch0 jump to 5: applied at boundary 60, high 20 of 60 clocks
    applyStimulus(2'd0, 4'd5, 1'b0);
    checkOutput("ch0_wr_busy", 32'(busy), 32'h1);
    checkOutput("ch0_wr_duty", 32'(duty), 32'h000);
    checkOutput("ch0_wr_err",  32'(cfgIf.cfg_err_o), 32'h0);
    stepTo(59);
    checkOutput("ch0_pre_bnd", 32'(duty), 32'h000);
    stepTo(60);
    checkOutput("ch0_bnd_duty", 32'(duty), 32'h005);
    checkOutput("ch0_bnd_busy", 32'(busy), 32'h0);
    stepTo(80);
    checkOutput("ch0_pwm_last_hi", 32'(fanPwm[0]), 32'h1);
    stepTo(81);
    checkOutput("ch0_pwm_first_lo", 32'(fanPwm[0]), 32'h0);
    countHigh(121, 180, 0, highCnt);
    checkOutput("ch0_hi_count5", 32'(highCnt), 32'd20);

    // ch1 ramp 0 -> 3, one LSB every second boundary
    applyStimulus(2'd1, 4'd3, 1'b1);
    checkOutput("ch1_ramp_busy", 32'(busy), 32'h2);
    stepTo(299);
    checkOutput("ch1_ramp_pre1", 32'(duty), 32'h005);
    stepTo(300);
    checkOutput("ch1_ramp_1", 32'(duty), 32'h015);
    stepTo(360);
    checkOutput("ch1_ramp_hold1", 32'(duty), 32'h015);
    stepTo(420);
    checkOutput("ch1_ramp_2", 32'(duty), 32'h025);
    checkOutput("ch1_ramp_busy2", 32'(busy), 32'h2);
    stepTo(540);
    checkOutput("ch1_ramp_3", 32'(duty), 32'h035);
    checkOutput("ch1_ramp_done", 32'(busy), 32'h0);
    stepTo(600);
    checkOutput("ch1_no_overshoot", 32'(duty), 32'h035);

    // ch1 jump to 15, then ramp down toward 0
    stepTo(601);
    applyStimulus(2'd1, 4'd15, 1'b0);
    stepTo(660);
    checkOutput("ch1_jump15", 32'(duty), 32'h0F5);
    stepTo(661);
    applyStimulus(2'd1, 4'd0, 1'b1);
    stepTo(720);
    checkOutput("ch1_down_hold", 32'(duty), 32'h0F5);
    checkOutput("ch1_down_busy", 32'(busy), 32'h2);
    stepTo(780);
    checkOutput("ch1_down_14", 32'(duty), 32'h0E5);
    stepTo(900);
    checkOutput("ch1_down_13", 32'(duty), 32'h0D5);
    stepTo(901);
    applyStimulus(2'd1, 4'd0, 1'b0);

    // ch2 at duty 0 stays low; at 15 stays high through the wrap
    countHigh(902, 960, 2, highCnt);
    checkOutput("ch2_zero_low", 32'(highCnt), 32'd0);
    applyStimulus(2'd2, 4'd15, 1'b0);
    stepTo(1020);
    checkOutput("ch2_pre_full_pwm", 32'(fanPwm[2]), 32'h0);
    checkOutput("ch2_full_duty", 32'(duty), 32'hF05);
    countHigh(1021, 1140, 2, highCnt);
    checkOutput("ch2_full_high", 32'(highCnt), 32'd120);
    applyStimulus(2'd2, 4'd0, 1'b0);
    stepTo(1200);
    checkOutput("ch2_off_last_hi", 32'(fanPwm[2]), 32'h1);
    checkOutput("ch2_off_duty", 32'(duty), 32'h005);
    stepTo(1201);
    checkOutput("ch2_off_lo", 32'(fanPwm[2]), 32'h0);

    // write coinciding with the period_end cycle (clock 1259)
    stepTo(1259);
    applyStimulus(2'd0, 4'd9, 1'b0);
    checkOutput("coinc_old_duty", 32'(duty), 32'h005);
    checkOutput("coinc_busy", 32'(busy), 32'h1);
    stepTo(1320);
    checkOutput("coinc_new_duty", 32'(duty), 32'h009);
    checkOutput("coinc_busy_clr", 32'(busy), 32'h0);
    countHigh(1321, 1380, 0, highCnt);
    checkOutput("ch0_hi_count9", 32'(highCnt), 32'd36);

    // out-of-range channel: one-cycle error pulse, no state change
    applyStimulus(2'd3, 4'd7, 1'b1);
    checkOutput("err_pulse", 32'(cfgIf.cfg_err_o), 32'h1);
    checkOutput("err_no_busy", 32'(busy), 32'h0);
    stepTo(1383);
    checkOutput("err_pulse_end", 32'(cfgIf.cfg_err_o), 32'h0);
    stepTo(1440);
    checkOutput("err_no_duty_chg", 32'(duty), 32'h009);

    // reset in the middle of a ch1 ramp
    stepTo(1441);
    applyStimulus(2'd1, 4'd4, 1'b1);
    stepTo(1560);
    checkOutput("mid_ramp_duty", 32'(duty), 32'h019);
    checkOutput("mid_ramp_busy", 32'(busy), 32'h2);
    rst = 1'b1;
    @(negedge clk);
    checkResetState("rst1");
    repeat (2) @(negedge clk);
    checkResetState("rst3");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("ready_after_rst2", 32'(cfgIf.cfg_ready_o), 32'h1);
    applyStimulus(2'd0, 4'd3, 1'b0);
    stepTo(59);
    checkOutput("post_rst_pre_bnd", 32'(duty), 32'h000);
    stepTo(60);
    checkOutput("post_rst_duty", 32'(duty), 32'h003);
    checkOutput("post_rst_busy", 32'(busy), 32'h0);

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
